// File: rtl/asmi_pkg.sv
// Shared encodings and helpers for the ASMI access arbiter.
package asmi_pkg;

  localparam int unsigned ASMI_ADDR_W = 24;
  localparam int unsigned PAGE_BYTES  = 256;
  localparam int unsigned CNT_W       = 9;

  localparam logic [1:0] CMD_READ    = 2'd0;
  localparam logic [1:0] CMD_ERASE   = 2'd1;
  localparam logic [1:0] CMD_WRITE   = 2'd2;
  localparam logic [1:0] CMD_ILLEGAL = 2'd3;

  typedef enum logic [3:0] {
    StIdle,
    StArbWait,
    StDecode,
    StErase,
    StWriteLoad,
    StWriteCmd,
    StReadCmd,
    StReadData,
    StWaitBusy,
    StFinish
  } state_e;

  // A length field of zero encodes a full page.
  function automatic logic [CNT_W-1:0] byte_target(input logic [CNT_W-1:0] len);
    return (len == '0) ? CNT_W'(PAGE_BYTES) : len;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick; the pointer remembers the last requester served.
module rr_arbiter2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       update_i,
  input  logic       owner_i,
  output logic       pick_o
);

  logic last_q;

  // Reset value of 1 makes requester 0 win the first tie.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else if (update_i) begin
      last_q <= owner_i;
    end
  end

  always_comb begin
    pick_o = 1'b0;
    unique case (req_i)
      2'b01:   pick_o = 1'b0;
      2'b10:   pick_o = 1'b1;
      2'b11:   pick_o = ~last_q;
      default: pick_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/asmi_access_arbiter.sv
// Shares one ASMI/EPCS flash macro between the programmer and the readback reader,
// sequencing one erase, page write or read per grant.
module asmi_access_arbiter
  import asmi_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 25000000,
  parameter int unsigned BUSY_BLANK     = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [1:0]               req,
  input  logic [3:0]               cmd,
  input  logic [2*ASMI_ADDR_W-1:0] addr,
  input  logic [2*CNT_W-1:0]       len,
  input  logic [15:0]              wdata,
  input  logic [1:0]               wshift,
  output logic [1:0]               grant,
  output logic [1:0]               done,
  output logic [1:0]               err,
  output logic [7:0]               rdata,
  output logic [1:0]               rvalid,
  output logic [ASMI_ADDR_W-1:0]   asmi_addr,
  output logic                     asmi_wren,
  output logic                     asmi_sector_erase,
  output logic                     asmi_write,
  output logic                     asmi_shift_bytes,
  output logic [7:0]               asmi_datain,
  output logic                     asmi_read,
  output logic                     asmi_rden,
  input  logic [7:0]               asmi_dataout,
  input  logic                     asmi_data_valid,
  input  logic                     asmi_busy
);

  state_e                 state_q, state_d;
  logic                   owner_q, owner_d;
  logic [1:0]             cmd_q, cmd_d;
  logic [ASMI_ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]       len_q, len_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [31:0]            tmr_q, tmr_d;
  logic                   err_flag_q, err_flag_d;
  logic [1:0]             grant_q, grant_d;
  logic [1:0]             done_q, done_d;
  logic [1:0]             err_q, err_d;
  logic [7:0]             rdata_q, rdata_d;
  logic [1:0]             rvalid_q, rvalid_d;

  logic             pick;
  logic             rr_update;
  logic             own_wshift;
  logic [7:0]       own_wdata;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] cnt_inc;

  rr_arbiter2 u_rr (
    .clk_i    (clock),
    .rst_i    (reset),
    .req_i    (req),
    .update_i (rr_update),
    .owner_i  (owner_q),
    .pick_o   (pick)
  );

  assign own_wshift = wshift[owner_q];
  assign own_wdata  = owner_q ? wdata[15:8] : wdata[7:0];
  assign target     = byte_target(len_q);
  assign cnt_inc    = cnt_q + 9'd1;

  assign grant     = grant_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign rvalid    = rvalid_q;
  assign asmi_addr = addr_q;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    tmr_d      = '0;
    err_flag_d = err_flag_q;
    grant_d    = grant_q;
    done_d     = '0;
    err_d      = '0;
    rdata_d    = rdata_q;
    rvalid_d   = '0;
    rr_update  = 1'b0;

    asmi_wren         = 1'b0;
    asmi_sector_erase = 1'b0;
    asmi_write        = 1'b0;
    asmi_shift_bytes  = 1'b0;
    asmi_datain       = '0;
    asmi_read         = 1'b0;
    asmi_rden         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (|req) begin
          owner_d    = pick;
          cmd_d      = pick ? cmd[3:2] : cmd[1:0];
          addr_d     = pick ? addr[2*ASMI_ADDR_W-1:ASMI_ADDR_W] : addr[ASMI_ADDR_W-1:0];
          len_d      = pick ? len[2*CNT_W-1:CNT_W] : len[CNT_W-1:0];
          grant_d    = pick ? 2'b10 : 2'b01;
          cnt_d      = '0;
          err_flag_d = 1'b0;
          state_d    = StArbWait;
        end
      end
      // Also covers a flash operation still running internally across a reset.
      StArbWait: begin
        if (!asmi_busy) state_d = StDecode;
      end
      StDecode: begin
        case (cmd_q)
          CMD_READ:  state_d = StReadCmd;
          CMD_ERASE: state_d = StErase;
          CMD_WRITE: state_d = StWriteLoad;
          default: begin
            err_flag_d = 1'b1;
            state_d    = StFinish;
          end
        endcase
      end
      StErase: begin
        asmi_wren         = 1'b1;
        asmi_sector_erase = 1'b1;
        state_d           = StWaitBusy;
      end
      StWriteLoad: begin
        asmi_wren   = 1'b1;
        asmi_datain = own_wdata;
        if (own_wshift) begin
          asmi_shift_bytes = 1'b1;
          cnt_d            = cnt_inc;
          if (cnt_inc == target) state_d = StWriteCmd;
        end
      end
      StWriteCmd: begin
        asmi_wren  = 1'b1;
        asmi_write = 1'b1;
        state_d    = StWaitBusy;
      end
      StReadCmd: begin
        asmi_read = 1'b1;
        asmi_rden = 1'b1;
        state_d   = StReadData;
      end
      StReadData: begin
        asmi_rden = 1'b1;
        if (asmi_data_valid) begin
          rdata_d  = asmi_dataout;
          rvalid_d = grant_q;
          cnt_d    = cnt_inc;
          if (cnt_inc == target) state_d = StWaitBusy;
        end
      end
      // tmr_q counts cycles already spent here; busy is not trusted right after the strobe.
      StWaitBusy: begin
        tmr_d = tmr_q + 32'd1;
        if ((tmr_q >= BUSY_BLANK) && !asmi_busy) begin
          state_d = StFinish;
        end else if (tmr_q == TIMEOUT_CYCLES - 1) begin
          err_flag_d = 1'b1;
          state_d    = StFinish;
        end
      end
      StFinish: begin
        done_d    = grant_q;
        err_d     = err_flag_q ? grant_q : 2'b00;
        grant_d   = '0;
        rr_update = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      owner_q    <= 1'b0;
      cmd_q      <= CMD_READ;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      tmr_q      <= '0;
      err_flag_q <= 1'b0;
      grant_q    <= '0;
      done_q     <= '0;
      err_q      <= '0;
      rdata_q    <= '0;
      rvalid_q   <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      tmr_q      <= tmr_d;
      err_flag_q <= err_flag_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

endmodule

// File: tb/tb_asmi_access_arbiter.sv
// Scoreboard bench for asmi_access_arbiter with a small flash busy model.
module tb_asmi_access_arbiter;

  localparam int unsigned TO = 50;
  localparam int unsigned BB = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [3:0]  cmd;
  logic [47:0] addr;
  logic [17:0] len;
  logic [15:0] wdata;
  logic [1:0]  wshift;
  logic [1:0]  grant, done, err, rvalid;
  logic [7:0]  rdata;
  logic [23:0] asmi_addr;
  logic        asmi_wren, asmi_sector_erase, asmi_write, asmi_shift_bytes;
  logic [7:0]  asmi_datain;
  logic        asmi_read, asmi_rden;
  logic [7:0]  asmi_dataout;
  logic        asmi_data_valid;
  logic        asmi_busy;

  always #5 clock = ~clock;

  asmi_access_arbiter #(
    .TIMEOUT_CYCLES (TO),
    .BUSY_BLANK     (BB)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .req               (req),
    .cmd               (cmd),
    .addr              (addr),
    .len               (len),
    .wdata             (wdata),
    .wshift            (wshift),
    .grant             (grant),
    .done              (done),
    .err               (err),
    .rdata             (rdata),
    .rvalid            (rvalid),
    .asmi_addr         (asmi_addr),
    .asmi_wren         (asmi_wren),
    .asmi_sector_erase (asmi_sector_erase),
    .asmi_write        (asmi_write),
    .asmi_shift_bytes  (asmi_shift_bytes),
    .asmi_datain       (asmi_datain),
    .asmi_read         (asmi_read),
    .asmi_rden         (asmi_rden),
    .asmi_dataout      (asmi_dataout),
    .asmi_data_valid   (asmi_data_valid),
    .asmi_busy         (asmi_busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Flash model: busy rises two cycles after an erase/write strobe for busy_len cycles.
  int unsigned busy_len = 40;
  logic        busy_force = 1'b0;
  logic        lag_q = 1'b0;
  int unsigned bcnt_q = 0;

  always @(posedge clock) begin
    lag_q <= asmi_sector_erase | asmi_write;
    if (lag_q) bcnt_q <= busy_len;
    else if (bcnt_q != 0) bcnt_q <= bcnt_q - 1;
  end
  assign asmi_busy = busy_force | (bcnt_q != 0);

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [25:0] exp_strobe_q[$];
  logic [7:0]  exp_shift_q[$];
  logic [9:0]  exp_rd_q[$];
  logic [3:0]  exp_done_q[$];
  int          grant_log[$];
  int          done_cnt = 0;
  int          strobe_cyc = 0;
  int          done_cyc = 0;
  logic [1:0]  grant_prev = 2'b00;

  always @(negedge clock) begin : monitor
    logic [1:0]  k;
    logic [25:0] es;
    logic [9:0]  er;
    logic [3:0]  ed;
    if (reset === 1'b0) begin
      check_eq("grant_onehot", {31'd0, $onehot0(grant)}, 32'd1);
      if (grant != 2'b00 && grant_prev == 2'b00) grant_log.push_back(int'(grant));
      grant_prev = grant;
      if (asmi_sector_erase || asmi_write || asmi_read) begin
        k = asmi_read ? 2'd0 : (asmi_sector_erase ? 2'd1 : 2'd2);
        strobe_cyc = cyc;
        if (exp_strobe_q.size() == 0) begin
          check_eq("strobe_extra", exp_strobe_q.size(), 1);
        end else begin
          es = exp_strobe_q.pop_front();
          check_eq("strobe_kind", k, es[25:24]);
          check_eq("strobe_addr", asmi_addr, es[23:0]);
          check_eq("strobe_wren", asmi_wren, k != 2'd0);
          check_eq("strobe_rden", asmi_rden, k == 2'd0);
        end
      end
      if (asmi_shift_bytes) begin
        if (exp_shift_q.size() == 0) begin
          check_eq("shift_extra", exp_shift_q.size(), 1);
        end else begin
          check_eq("shift_datain", asmi_datain, exp_shift_q.pop_front());
          check_eq("shift_wren", asmi_wren, 1);
        end
      end
      if (rvalid != 2'b00) begin
        if (exp_rd_q.size() == 0) begin
          check_eq("rvalid_extra", exp_rd_q.size(), 1);
        end else begin
          er = exp_rd_q.pop_front();
          check_eq("rvalid_mask", rvalid, er[9:8]);
          check_eq("rdata", rdata, er[7:0]);
        end
      end
      if (done != 2'b00 || err != 2'b00) begin
        done_cnt++;
        done_cyc = cyc;
        if (exp_done_q.size() == 0) begin
          check_eq("done_extra", exp_done_q.size(), 1);
        end else begin
          ed = exp_done_q.pop_front();
          check_eq("done_mask", done, ed[3:2]);
          check_eq("err_mask", err, ed[1:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_grant(input logic [1:0] m, input string tag);
    for (int i = 0; i < 400 && grant !== m; i++) tick();
    check_eq(tag, grant, m);
  endtask

  task automatic wait_done(input int n, input string tag);
    for (int i = 0; i < 600 && done_cnt < n; i++) tick();
    check_eq(tag, done_cnt, n);
  endtask

  task automatic wait_wren(input string tag);
    for (int i = 0; i < 100 && asmi_wren !== 1'b1; i++) tick();
    check_eq(tag, asmi_wren, 1);
  endtask

  task automatic wait_rden(input string tag);
    for (int i = 0; i < 100 && asmi_rden !== 1'b1; i++) tick();
    check_eq(tag, asmi_rden, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_grant"}, grant, 0);
    check_eq({tag, "_done_err_rvalid"}, {done, err, rvalid}, 0);
    check_eq({tag, "_rdata"}, rdata, 0);
    check_eq({tag, "_strobes"},
             {asmi_wren, asmi_sector_erase, asmi_write, asmi_shift_bytes, asmi_read, asmi_rden}, 0);
    check_eq({tag, "_addr"}, asmi_addr, 0);
    check_eq({tag, "_datain"}, asmi_datain, 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1);
  end

  initial begin : stim
    logic [7:0] rb [4];
    rb = '{8'hA5, 8'h5A, 8'h01, 8'hFE};
    req = '0; cmd = '0; addr = '0; len = '0; wdata = '0; wshift = '0;
    asmi_dataout = '0; asmi_data_valid = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    check_all_zero("rst");
    reset = 1'b0;
    tick();

    // Programmer sector erase.
    busy_len = 40;
    exp_strobe_q.push_back({2'd1, 24'h100000});
    exp_done_q.push_back(4'b0100);
    req = 2'b01; cmd = 4'b0001; addr = {24'h0, 24'h100000};
    wait_grant(2'b01, "erase_grant");
    req = 2'b00;
    wait_done(1, "erase_done");
    check_eq("erase_latency", done_cyc - strobe_cyc, 40 + 4);

    // Programmer full-page write; non-owner wshift must be ignored.
    busy_len = 10;
    exp_strobe_q.push_back({2'd2, 24'h020000});
    exp_done_q.push_back(4'b0100);
    req = 2'b01; cmd = 4'b0010; addr = {24'h777777, 24'h020000}; len = {9'd5, 9'd0};
    wait_grant(2'b01, "write_grant");
    req = 2'b00; addr = '1; len = '1; cmd = '1;
    wait_wren("write_load_wren");
    for (int i = 0; i < 256; i++) begin
      if (i % 37 == 5) begin
        wshift = 2'b10; wdata = 16'hEE77;
        tick();
      end
      exp_shift_q.push_back(i[7:0]);
      wshift = (i % 5 == 0) ? 2'b11 : 2'b01;
      wdata  = {8'hC3, i[7:0]};
      tick();
    end
    wshift = 2'b00;
    wait_done(2, "write_done");
    wshift = 2'b10;
    repeat (5) tick();
    wshift = 2'b00;
    check_eq("write_shift_drained", exp_shift_q.size(), 0);

    // Reader 4-byte read.
    exp_strobe_q.push_back({2'd0, 24'h000010});
    for (int i = 0; i < 4; i++) exp_rd_q.push_back({2'b10, rb[i]});
    exp_done_q.push_back(4'b1000);
    req = 2'b10; cmd = 4'b0001; addr = {24'h000010, 24'h123456}; len = {9'd4, 9'd100};
    wait_grant(2'b10, "read_grant");
    req = 2'b00;
    wait_rden("read_rden");
    for (int i = 0; i < 4; i++) begin
      tick();
      asmi_dataout = rb[i]; asmi_data_valid = 1'b1;
      tick();
      asmi_data_valid = 1'b0;
    end
    check_eq("read_rden_drop", asmi_rden, 0);
    wait_done(3, "read_done");

    // Both requests held from reset: grants must alternate starting at requester 0.
    busy_len = 3;
    reset = 1'b1;
    req = 2'b11; cmd = {2'd3, 2'd1}; addr = {24'h0, 24'h0ABC00}; len = '0;
    repeat (2) tick();
    grant_log.delete();
    exp_strobe_q.push_back({2'd1, 24'h0ABC00});
    exp_strobe_q.push_back({2'd1, 24'h0ABC00});
    exp_done_q.push_back(4'b0100);
    exp_done_q.push_back(4'b1010);
    exp_done_q.push_back(4'b0100);
    exp_done_q.push_back(4'b1010);
    reset = 1'b0;
    for (int i = 0; i < 400 && grant_log.size() < 4; i++) tick();
    req = 2'b00;
    wait_done(7, "rr_done");
    check_eq("rr_grant_count", grant_log.size(), 4);
    for (int i = 0; i < 4; i++) check_eq("rr_grant_seq", grant_log[i], (i % 2 == 0) ? 1 : 2);

    // Busy stuck high past the timeout.
    busy_len = 200;
    exp_strobe_q.push_back({2'd1, 24'h3F0000});
    exp_done_q.push_back(4'b0101);
    req = 2'b01; cmd = 4'b0001; addr = {24'h0, 24'h3F0000};
    wait_grant(2'b01, "to_grant");
    req = 2'b00;
    wait_done(8, "to_done");
    check_eq("to_latency", done_cyc - strobe_cyc, TO + BB);
    busy_len = 4;
    exp_strobe_q.push_back({2'd1, 24'h001000});
    exp_done_q.push_back(4'b1000);
    req = 2'b10; cmd = 4'b0100; addr = {24'h001000, 24'h0};
    wait_grant(2'b10, "to_next_grant");
    req = 2'b00;
    wait_done(9, "to_next_done");

    // Reset in the middle of a page write, then an illegal command while flash is busy.
    busy_len = 10;
    req = 2'b01; cmd = 4'b0010; addr = {24'h0, 24'h040000}; len = {9'd0, 9'd8};
    wait_grant(2'b01, "midrst_write_grant");
    req = 2'b00;
    wait_wren("midrst_wren");
    for (int i = 1; i <= 3; i++) begin
      exp_shift_q.push_back(8'(i * 8'h11));
      wshift = 2'b01; wdata = {8'h00, 8'(i * 8'h11)};
      tick();
    end
    wshift = 2'b00;
    busy_force = 1'b1;
    reset = 1'b1;
    tick();
    check_all_zero("midrst");
    reset = 1'b0;
    exp_done_q.push_back(4'b1010);
    req = 2'b10; cmd = 4'b1100;
    wait_grant(2'b10, "midrst_grant");
    req = 2'b00;
    repeat (20) tick();
    check_eq("midrst_held_busy", done_cnt, 9);
    busy_force = 1'b0;
    wait_done(10, "illegal_done");

    check_eq("strobe_q_empty", exp_strobe_q.size(), 0);
    check_eq("shift_q_empty", exp_shift_q.size(), 0);
    check_eq("rd_q_empty", exp_rd_q.size(), 0);
    check_eq("done_q_empty", exp_done_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
